// File: rtl/framebuffer_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter and its surroundings:
// display beam, pixel writer, single-port RAM and status.
interface framebuffer_arbiter_if #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    // display side
    logic              iDE;
    logic [ADDR_W-1:0] iPos;
    logic [DATA_W-1:0] oPixel;
    logic              oPixelValid;

    // writer side
    logic              iWrValid;
    logic              oWrReady;
    logic [ADDR_W-1:0] iWrAddr;
    logic [DATA_W-1:0] iWrData;

    // RAM side
    logic [ADDR_W-1:0] oMemAddr;
    logic              oMemWe;
    logic [DATA_W-1:0] oMemWData;
    logic [DATA_W-1:0] iMemRData;

    // status
    logic [CNT_W-1:0]  oFifoCount;
    logic              oWrOverflow;

    // arbiter view
    modport slave (
        input  iDE, iPos, iWrValid, iWrAddr, iWrData, iMemRData,
        output oPixel, oPixelValid, oWrReady, oMemAddr, oMemWe, oMemWData,
               oFifoCount, oWrOverflow
    );

    // environment view (beam generator, writer, RAM)
    modport master (
        output iDE, iPos, iWrValid, iWrAddr, iWrData, iMemRData,
        input  oPixel, oPixelValid, oWrReady, oMemAddr, oMemWe, oMemWData,
               oFifoCount, oWrOverflow
    );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Frame-buffer arbiter: shares one single-port RAM between display scan-out
// (absolute priority while iDE is low) and a writer whose requests are queued
// in a small FWFT FIFO and drained during blanking. Scan-out pixels come back
// with a fixed latency of RD_LAT+2 cycles after the display request.
module framebuffer_arbiter #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                   iClk,
    input  logic                   iRst,
    framebuffer_arbiter_if.slave   bus
);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OVF_W     = 10;
    localparam int unsigned OVF_LIMIT = 640;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_WR   = 2'd2
    } grant_e;

    // write FIFO storage and pointers
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // registered RAM port
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // read-tag pipeline: bit k marks a display read issued k+1 cycles ago
    logic [RD_LAT:0]   rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] pixel_q, pixel_d;
    logic              pixel_vld_q, pixel_vld_d;

    // overflow watchdog
    logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic              ovf_q, ovf_d;

    grant_e            grant_c;
    logic              wr_ready_c;
    logic              push_c;
    logic              pop_c;
    logic              stall_c;

    // Ready depends only on the count register and reset, never on iWrValid.
    assign wr_ready_c = !iRst && (count_q < CNT_W'(FIFO_DEPTH));
    assign push_c     = bus.iWrValid && wr_ready_c;
    assign stall_c    = bus.iWrValid && (count_q == CNT_W'(FIFO_DEPTH));

    // Per-cycle grant: display first, then a queued write, otherwise idle.
    always_comb begin
        grant_c = GNT_IDLE;
        if (!bus.iDE) begin
            grant_c = GNT_DISP;
        end else if (count_q != '0) begin
            grant_c = GNT_WR;
        end
    end

    assign pop_c = (grant_c == GNT_WR);

    // Next-state for RAM port, FIFO bookkeeping, read pipeline and watchdog.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_cnt_d   = ovf_cnt_q;
        ovf_d       = ovf_q;

        case (grant_c)
            GNT_DISP: begin
                mem_addr_d = bus.iPos;
            end
            GNT_WR: begin
                mem_addr_d  = fifo_addr_q[rd_ptr_q];
                mem_wdata_d = fifo_data_q[rd_ptr_q];
                mem_we_d    = 1'b1;
            end
            default: begin
            end
        endcase

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // RAM data lines up with the oldest tag; non-read slots output black.
        rd_vld_d    = {rd_vld_q[RD_LAT-1:0], (grant_c == GNT_DISP)};
        pixel_vld_d = rd_vld_q[RD_LAT];
        pixel_d     = rd_vld_q[RD_LAT] ? bus.iMemRData : '0;

        // Sticky flag after a full line's worth of stalled write requests.
        if (stall_c) begin
            if (ovf_cnt_q == OVF_W'(OVF_LIMIT - 1)) begin
                ovf_d = 1'b1;
            end
            if (ovf_cnt_q != OVF_W'(OVF_LIMIT)) begin
                ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
            end
        end else begin
            ovf_cnt_d = '0;
        end
    end

    // State registers with synchronous reset; reset drops queued writes and in-flight reads.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rd_vld_q    <= '0;
            pixel_q     <= '0;
            pixel_vld_q <= 1'b0;
            ovf_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rd_vld_q    <= rd_vld_d;
            pixel_q     <= pixel_d;
            pixel_vld_q <= pixel_vld_d;
            ovf_cnt_q   <= ovf_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO payload storage; contents are meaningless once pointers are reset.
    always_ff @(posedge iClk) begin
        if (push_c) begin
            fifo_addr_q[wr_ptr_q] <= bus.iWrAddr;
            fifo_data_q[wr_ptr_q] <= bus.iWrData;
        end
    end

    assign bus.oWrReady    = wr_ready_c;
    assign bus.oMemAddr    = mem_addr_q;
    assign bus.oMemWe      = mem_we_q;
    assign bus.oMemWData   = mem_wdata_q;
    assign bus.oPixel      = pixel_q;
    assign bus.oPixelValid = pixel_vld_q;
    assign bus.oFifoCount  = count_q;
    assign bus.oWrOverflow = ovf_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_framebuffer_arbiter;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned RD_LAT = 1;
    localparam int          OVF_CYCLES = 640;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    framebuffer_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

    framebuffer_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus)
    );

    // RAM model driven by the DUT's RAM port, one-cycle read latency
    logic [DATA_W-1:0] ram [int];

    function automatic logic [DATA_W-1:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : '0;
    endfunction

    always @(posedge clk) begin
        if (bus.oMemWe === 1'b1) ram[int'(bus.oMemAddr)] = bus.oMemWData;
        bus.iMemRData <= ram_rd(int'(bus.oMemAddr));
    end

    // reference model
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;
    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
    } pix_t;

    wr_t               fifo_m[$];
    pix_t              pix_m[$];
    logic [DATA_W-1:0] ref_ram [int];
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    logic              exp_ovf;
    int                ovf_run;

    int checks   = 0;
    int failures = 0;

    function automatic logic [DATA_W-1:0] ref_rd(input int a);
        return ref_ram.exists(a) ? ref_ram[a] : '0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        pix_t z;
        z.v = 1'b0;
        z.d = '0;
        fifo_m.delete();
        pix_m.delete();
        repeat (3) pix_m.push_back(z);
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_ovf   = 1'b0;
        ovf_run   = 0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input logic r, input logic de, input logic [ADDR_W-1:0] pos,
                        input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        pix_t p;
        pix_t n;
        wr_t  e;
        logic exp_ready;
        rst          = r;
        bus.iDE      = de;
        bus.iPos     = pos;
        bus.iWrValid = wv;
        bus.iWrAddr  = wa;
        bus.iWrData  = wd;
        #1;
        exp_ready = !r && (fifo_m.size() < DEPTH);
        p = pix_m.pop_front();
        check_eq("wr_ready",    32'(bus.oWrReady),    32'(exp_ready));
        check_eq("fifo_count",  32'(bus.oFifoCount),  32'(fifo_m.size()));
        check_eq("mem_we",      32'(bus.oMemWe),      32'(exp_we));
        check_eq("mem_addr",    32'(bus.oMemAddr),    32'(exp_addr));
        check_eq("mem_wdata",   32'(bus.oMemWData),   32'(exp_wdata));
        check_eq("pixel_valid", 32'(bus.oPixelValid), 32'(p.v));
        check_eq("pixel",       32'(bus.oPixel),      32'(p.d));
        check_eq("overflow",    32'(bus.oWrOverflow), 32'(exp_ovf));

        if (r) begin
            model_reset();
        end else begin
            if (wv && fifo_m.size() == DEPTH) ovf_run++;
            else                              ovf_run = 0;
            if (ovf_run >= OVF_CYCLES) exp_ovf = 1'b1;

            n.v = 1'b0;
            n.d = '0;
            exp_we = 1'b0;
            if (!de) begin
                exp_addr = pos;
                n.v = 1'b1;
                n.d = ref_rd(int'(pos));
            end else if (fifo_m.size() > 0) begin
                e = fifo_m.pop_front();
                exp_we    = 1'b1;
                exp_addr  = e.a;
                exp_wdata = e.d;
                ref_ram[int'(e.a)] = e.d;
            end
            pix_m.push_back(n);

            if (wv && exp_ready) begin
                e.a = wa;
                e.d = wd;
                fifo_m.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic de);
        for (int i = 0; i < n; i++) step(1'b0, de, ADDR_W'(i), 1'b0, '0, '0);
    endtask

    initial begin
        logic              de;
        logic              wv;
        logic              r;
        logic [ADDR_W-1:0] pos;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;

        rst           = 1'b1;
        bus.iDE       = 1'b1;
        bus.iPos      = '0;
        bus.iWrValid  = 1'b0;
        bus.iWrAddr   = '0;
        bus.iWrData   = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset held with a pending write request, then release
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0, 1'b1, 19'h00010, 12'hABC);
        idle(2, 1'b1);

        // single write during blanking
        step(1'b0, 1'b1, '0, 1'b1, 19'h00010, 12'hABC);
        idle(3, 1'b1);

        // seed address 5, then read it back during active video
        step(1'b0, 1'b1, '0, 1'b1, 19'd5, 12'h123);
        idle(2, 1'b1);
        step(1'b0, 1'b0, 19'd5, 1'b0, '0, '0);
        idle(4, 1'b1);

        // fill while active: only DEPTH accepted, drained in order on blanking
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, ADDR_W'(i), 1'b1, ADDR_W'(32'h100 + i), DATA_W'($urandom));
        idle(12, 1'b1);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, ADDR_W'(i), 1'b1, ADDR_W'(32'h200 + i), DATA_W'($urandom));
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, '0, 1'b1, ADDR_W'(32'h300 + i), DATA_W'($urandom));
        idle(12, 1'b1);

        // mid-frame reset with five queued writes
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, ADDR_W'(i), 1'b1, ADDR_W'(32'h400 + i), DATA_W'($urandom));
        step(1'b1, 1'b0, 19'd3, 1'b1, 19'h00410, 12'h555);
        idle(6, 1'b1);

        // writer stalled behind a full FIFO for a whole active line
        for (int i = 0; i < 660; i++)
            step(1'b0, 1'b0, ADDR_W'(i), 1'b1, 19'h00500, DATA_W'($urandom));
        idle(2, 1'b1);
        step(1'b1, 1'b1, '0, 1'b0, '0, '0);
        idle(2, 1'b1);

        // randomized traffic over a small address window to exercise read/write overlap
        for (int i = 0; i < 3000; i++) begin
            de  = ((i % 24) >= 16) ? 1'b1 : ($urandom_range(0, 15) == 0);
            wv  = ($urandom_range(0, 1) == 1);
            r   = ($urandom_range(0, 499) == 0);
            pos = ADDR_W'($urandom_range(0, 31));
            wa  = ADDR_W'($urandom_range(0, 31));
            wd  = DATA_W'($urandom);
            step(r, de, pos, wv, wa, wd);
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
